ll_par_arbiter: RTL and testbench

- Shares the single linked-list manager page-allocation interface between several packet allocators.
- The shared interface is the page request handshake (par) and the page return handshake (parr carrying the page number).
- Round-robin arbitration on requests; each grant records the requester index in an in-order tag queue.
- Returned pages are steered to the requester at the head of the tag queue, because the manager returns pages strictly in request order.

---
 rtl/ll_pkg.sv | 13 +
 rtl/ll_rr_grant.sv | 33 +++
 rtl/ll_par_arbiter.sv | 103 ++++++++++
 tb/tb_ll_par_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// Shared linked-list manager constants and helpers used by the
// page-allocation arbiter and related request arbiters.
package ll_pkg;

  localparam int LL_PG_ASZ  = 7;
  localparam int LL_MAX_OUT = 8;

  // Width of a requester index; never zero so single-port builds still elaborate.
  function automatic int tag_width(input int inputs);
    return (inputs <= 1) ? 1 : $clog2(inputs);
  endfunction

endpackage

// File: rtl/ll_rr_grant.sv
// Round-robin grant: picks the first asserted request at or above the
// pointer, wrapping, and reports it both one-hot and encoded.
module ll_rr_grant
  import ll_pkg::*;
#(
  parameter int inputs = 2,
  parameter int tw     = tag_width(inputs)
) (
  input  logic [inputs-1:0] req_i,
  input  logic [tw-1:0]     ptr_i,
  output logic [inputs-1:0] grant_o,
  output logic [tw-1:0]     idx_o
);

  int   cand;
  logic found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < inputs; i++) begin
      cand = (int'(ptr_i) + i) % inputs;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = tw'(cand);
      end
    end
  end

endmodule

// File: rtl/ll_par_arbiter.sv
// Shares the linked-list manager page request/return handshakes between
// several allocators; returns are steered by an in-order tag queue.
module ll_par_arbiter
  import ll_pkg::*;
#(
  parameter int inputs  = 2,
  parameter int pg_asz  = LL_PG_ASZ,
  parameter int max_out = LL_MAX_OUT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [inputs-1:0]          c_par_srdy,
  output logic [inputs-1:0]          c_par_drdy,
  output logic [inputs-1:0]          c_parr_srdy,
  input  logic [inputs-1:0]          c_parr_drdy,
  output logic [inputs*pg_asz-1:0]   c_parr_page,
  output logic                       p_par_srdy,
  input  logic                       p_par_drdy,
  input  logic                       p_parr_srdy,
  output logic                       p_parr_drdy,
  input  logic [pg_asz-1:0]          p_parr_page,
  output logic [$clog2(max_out):0]   outstanding,
  output logic                       err_unsolicited
);

  localparam int TW = tag_width(inputs);
  localparam int AW = $clog2(max_out);

  logic [TW-1:0]     tags_q [max_out];
  logic [AW-1:0]     wr_q, rd_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic [TW-1:0]     rr_q, rr_d;
  logic              err_q, err_d;

  logic [inputs-1:0] grant;
  logic [TW-1:0]     gidx;
  logic [TW-1:0]     head;
  logic              full, empty, push, pop;

  ll_rr_grant #(
    .inputs (inputs),
    .tw     (TW)
  ) u_grant (
    .req_i   (c_par_srdy),
    .ptr_i   (rr_q),
    .grant_o (grant),
    .idx_o   (gidx)
  );

  assign full  = (cnt_q == (AW+1)'(max_out));
  assign empty = (cnt_q == '0);
  assign head  = tags_q[rd_q];

  assign p_par_srdy  = (|c_par_srdy) && !full;
  assign c_par_drdy  = grant & {inputs{p_par_drdy && !full}};
  assign push        = p_par_srdy && p_par_drdy;

  assign p_parr_drdy = !empty && c_parr_drdy[head];
  assign pop         = p_parr_srdy && p_parr_drdy;
  assign c_parr_page = {inputs{p_parr_page}};

  assign outstanding     = cnt_q;
  assign err_unsolicited = err_q;

  always_comb begin
    c_parr_srdy = '0;
    if (p_parr_srdy && !empty) c_parr_srdy[head] = 1'b1;
  end

  always_comb begin
    rr_d  = rr_q;
    cnt_d = cnt_q;
    err_d = err_q | (p_parr_srdy & empty);
    if (push) rr_d = (gidx == TW'(inputs - 1)) ? '0 : gidx + TW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_d;
      rr_q  <= rr_d;
      err_q <= err_d;
    end
  end

  // Tag storage is pure datapath; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) tags_q[wr_q] <= gidx;
  end

endmodule

// File: tb/tb_ll_par_arbiter.sv
// Directed self-checking bench for ll_par_arbiter with inputs=2,
// pg_asz=7, max_out=8.
module tb_ll_par_arbiter;

  localparam int N  = 2;
  localparam int PA = 7;
  localparam int MO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    c_par_srdy, c_par_drdy, c_parr_srdy, c_parr_drdy;
  logic [N*PA-1:0] c_parr_page;
  logic            p_par_srdy, p_par_drdy, p_parr_srdy, p_parr_drdy;
  logic [PA-1:0]   p_parr_page;
  logic [3:0]      outstanding;
  logic            err_unsolicited;

  int testsRun    = 0;
  int testsFailed = 0;

  ll_par_arbiter #(.inputs(N), .pg_asz(PA), .max_out(MO)) dut (
    .clk             (clk),
    .reset           (reset),
    .c_par_srdy      (c_par_srdy),
    .c_par_drdy      (c_par_drdy),
    .c_parr_srdy     (c_parr_srdy),
    .c_parr_drdy     (c_parr_drdy),
    .c_parr_page     (c_parr_page),
    .p_par_srdy      (p_par_srdy),
    .p_par_drdy      (p_par_drdy),
    .p_parr_srdy     (p_parr_srdy),
    .p_parr_drdy     (p_parr_drdy),
    .p_parr_page     (p_parr_page),
    .outstanding     (outstanding),
    .err_unsolicited (err_unsolicited)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic pdrdy,
                               input logic rsrdy, input logic [N-1:0] rdrdy,
                               input logic [PA-1:0] page);
    c_par_srdy  = req;
    p_par_drdy  = pdrdy;
    p_parr_srdy = rsrdy;
    c_parr_drdy = rdrdy;
    p_parr_page = page;
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    checkOutput({tag, "_p_par_srdy"},  32'(p_par_srdy),  32'd0);
    checkOutput({tag, "_c_par_drdy"},  32'(c_par_drdy),  32'd0);
    checkOutput({tag, "_c_parr_srdy"}, 32'(c_parr_srdy), 32'd0);
    checkOutput({tag, "_p_parr_drdy"}, 32'(p_parr_drdy), 32'd0);
  endtask

  logic [1:0] fairGrant [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] retPort   [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    reset = 1'b1;
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkIdle("reset");
    checkOutput("reset_err", 32'(err_unsolicited), 32'd0);

    // Fairness: both ports request, grants alternate from port 0
    for (int i = 0; i < 6; i++) begin
      applyStimulus(2'b11, 1'b1, 1'b0, '0, '0);
      checkOutput($sformatf("fair_grant%0d", i), 32'(c_par_drdy), 32'(fairGrant[i]));
      checkOutput($sformatf("fair_psrdy%0d", i), 32'(p_par_srdy), 32'd1);
      tick();
    end
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    checkOutput("fair_outstanding", 32'(outstanding), 32'd6);

    // In-order returns of pages 10..15
    for (int i = 0; i < 6; i++) begin
      applyStimulus('0, 1'b0, 1'b1, 2'b11, PA'(10 + i));
      checkOutput($sformatf("ret_port%0d", i), 32'(c_parr_srdy), 32'(retPort[i]));
      checkOutput($sformatf("ret_page%0d", i), 32'(c_parr_page), (32'(10 + i) << PA) | 32'(10 + i));
      checkOutput($sformatf("ret_pdrdy%0d", i), 32'(p_parr_drdy), 32'd1);
      tick();
    end
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    checkOutput("ret_outstanding", 32'(outstanding), 32'd0);

    // Full: port 0 alone, granted every cycle until the queue holds 8
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0, '0, '0);
      checkOutput($sformatf("single_grant%0d", i), 32'(c_par_drdy), 32'd1);
      tick();
    end
    checkOutput("full_outstanding", 32'(outstanding), 32'd8);
    checkOutput("full_psrdy", 32'(p_par_srdy), 32'd0);
    checkOutput("full_cdrdy", 32'(c_par_drdy), 32'd0);
    applyStimulus(2'b01, 1'b1, 1'b1, 2'b01, PA'(20));
    checkOutput("full_ret_srdy", 32'(c_parr_srdy), 32'd1);
    checkOutput("full_ret_pdrdy", 32'(p_parr_drdy), 32'd1);
    checkOutput("full_ret_nogrant", 32'(c_par_drdy), 32'd0);
    tick();
    checkOutput("after_ret_outstanding", 32'(outstanding), 32'd7);
    checkOutput("after_ret_grant", 32'(c_par_drdy), 32'd1);
    tick();
    checkOutput("pushpop_outstanding", 32'(outstanding), 32'd7);
    for (int i = 0; i < 7; i++) begin
      applyStimulus('0, 1'b0, 1'b1, 2'b01, PA'(40 + i));
      tick();
    end
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    checkOutput("drain_outstanding", 32'(outstanding), 32'd0);

    // Head-of-line block: pointer is at 1, so tags become [1,0]
    applyStimulus(2'b11, 1'b1, 1'b0, '0, '0);
    checkOutput("hol_grant_a", 32'(c_par_drdy), 32'd2);
    tick();
    applyStimulus(2'b11, 1'b1, 1'b0, '0, '0);
    checkOutput("hol_grant_b", 32'(c_par_drdy), 32'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, 1'b0, 1'b1, 2'b01, PA'(30));
      checkOutput($sformatf("hol_pdrdy%0d", i), 32'(p_parr_drdy), 32'd0);
      checkOutput($sformatf("hol_srdy%0d", i), 32'(c_parr_srdy), 32'd2);
      tick();
      checkOutput($sformatf("hol_outstanding%0d", i), 32'(outstanding), 32'd2);
    end
    applyStimulus('0, 1'b0, 1'b1, 2'b11, PA'(30));
    checkOutput("hol_release_srdy", 32'(c_parr_srdy), 32'd2);
    checkOutput("hol_release_pdrdy", 32'(p_parr_drdy), 32'd1);
    tick();
    applyStimulus('0, 1'b0, 1'b1, 2'b11, PA'(31));
    checkOutput("hol_next_srdy", 32'(c_parr_srdy), 32'd1);
    checkOutput("hol_next_page", 32'(c_parr_page[PA-1:0]), 32'd31);
    tick();
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    checkOutput("hol_outstanding_end", 32'(outstanding), 32'd0);

    // Unsolicited return while empty
    applyStimulus('0, 1'b0, 1'b1, 2'b11, PA'(5));
    checkOutput("unsol_pdrdy", 32'(p_parr_drdy), 32'd0);
    checkOutput("unsol_srdy", 32'(c_parr_srdy), 32'd0);
    tick();
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    checkOutput("unsol_err", 32'(err_unsolicited), 32'd1);
    tick();
    tick();
    checkOutput("unsol_err_sticky", 32'(err_unsolicited), 32'd1);
    checkOutput("unsol_outstanding", 32'(outstanding), 32'd0);

    // Reset mid-operation with the pointer left at 1
    for (int i = 0; i < 3; i++) begin
      applyStimulus(2'b01, 1'b1, 1'b0, '0, '0);
      tick();
    end
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    checkOutput("mid_outstanding", 32'(outstanding), 32'd3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checkIdle("midreset");
    checkOutput("midreset_err", 32'(err_unsolicited), 32'd0);
    applyStimulus(2'b11, 1'b1, 1'b0, '0, '0);
    checkOutput("midreset_grant", 32'(c_par_drdy), 32'd1);
    tick();
    applyStimulus('0, 1'b0, 1'b0, '0, '0);
    checkOutput("midreset_outstanding", 32'(outstanding), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
